// File: rtl/uart_pkg.sv
// Shared definitions for the 6809<->FT2232 UART: FSM encoding, register bit
// positions and the default bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // 9600 bps from a 44.33 MHz system clock
    localparam int DEFAULT_CLOCK_DIVISOR = 4618;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVERRUN = 3;
    localparam int STAT_CNT_LO  = 4;
    localparam int STAT_CNT_HI  = 6;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the 6809 write port and the TX serialiser. A push is
// accepted when full only if a pop frees a slot in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && !flush && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Flush is a level: the queue stays empty for as long as it is held
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_interface.sv
// Transmit half of the 6809<->FT2232 UART: TX FIFO feeding an 8N1 LSB-first
// serialiser, with status register and active-low drain interrupt.
module uart_tx_interface
    import uart_pkg::*;
#(
    parameter int CLOCK_DIVISOR = DEFAULT_CLOCK_DIVISOR,
    parameter int DIV_W         = 13,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tx_wr,
    input  logic [7:0] i_tx_data,
    input  logic [7:0] i_control,
    input  logic       i_status_rd,
    output logic       o_UART_RX,
    output logic [7:0] o_tx_status,
    output logic       o_IRQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] BIT_LAST = DIV_W'(CLOCK_DIVISOR - 1);

    uart_state_t      state, state_nx;
    logic [DIV_W-1:0] baud_cnt, baud_nx;
    logic [2:0]       bit_idx, bit_nx;
    logic [7:0]       shreg, sh_nx;
    logic             line_nx;
    logic             pop;
    logic             bit_end;
    logic             overrun;
    logic             wr_drop;
    logic             tx_empty;

    logic             tx_en, irq_en, flush;
    logic [7:0]       fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;

    assign tx_en  = i_control[CTRL_TX_EN];
    assign irq_en = i_control[CTRL_IRQ_EN];
    assign flush  = i_control[CTRL_FLUSH];

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (i_tx_wr),
        .pop   (pop),
        .flush (flush),
        .wdata (i_tx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (baud_cnt == BIT_LAST);

    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt + 1'b1;
        bit_nx   = bit_idx;
        sh_nx    = shreg;
        pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                baud_nx = '0;
                if (tx_en && !fifo_empty) begin
                    pop      = 1'b1;
                    sh_nx    = fifo_rdata;
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_nx = '0;
                    sh_nx   = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) state_nx = ST_STOP;
                    else                 bit_nx   = bit_idx + 3'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_nx = '0;
                    // Chain straight into the next start bit so queued bytes go out gap-free
                    if (tx_en && !fifo_empty) begin
                        pop      = 1'b1;
                        sh_nx    = fifo_rdata;
                        state_nx = ST_START;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        line_nx = 1'b1;
        if (state_nx == ST_START)     line_nx = 1'b0;
        else if (state_nx == ST_DATA) line_nx = sh_nx[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            o_UART_RX <= 1'b1;
        end else begin
            state     <= state_nx;
            baud_cnt  <= baud_nx;
            bit_idx   <= bit_nx;
            shreg     <= sh_nx;
            o_UART_RX <= line_nx;
        end
    end

    // A write lost to a full queue; writes during flush are discarded silently
    assign wr_drop = i_tx_wr && !flush && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (reset)            overrun <= 1'b0;
        else if (wr_drop)     overrun <= 1'b1;
        else if (i_status_rd) overrun <= 1'b0;
    end

    assign tx_empty = fifo_empty && (state == ST_IDLE);

    always_comb begin
        o_tx_status                           = '0;
        o_tx_status[STAT_EMPTY]               = tx_empty;
        o_tx_status[STAT_FULL]                = fifo_full;
        o_tx_status[STAT_BUSY]                = (state != ST_IDLE);
        o_tx_status[STAT_OVERRUN]             = overrun;
        o_tx_status[STAT_CNT_HI:STAT_CNT_LO]  = 3'(fifo_count);
    end

    always_ff @(posedge clk) begin
        if (reset) o_IRQ <= 1'b1;
        else       o_IRQ <= ~(irq_en && tx_empty);
    end

endmodule

// File: tb/tb_uart_tx_interface.sv
// Directed bench for uart_tx_interface at 4 clocks per bit: framing, back-to-back
// frames, overrun, enable gating, IRQ timing, reset abort and flush.
module tb_uart_tx_interface;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_tx_wr;
    logic [7:0] i_tx_data;
    logic [7:0] i_control;
    logic       i_status_rd;
    logic       o_UART_RX;
    logic [7:0] o_tx_status;
    logic       o_IRQ;

    int errors = 0;
    int checks = 0;

    uart_tx_interface #(.CLOCK_DIVISOR(BD), .DIV_W(4), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_tx_wr     (i_tx_wr),
        .i_tx_data   (i_tx_data),
        .i_control   (i_control),
        .i_status_rd (i_status_rd),
        .o_UART_RX   (o_UART_RX),
        .o_tx_status (o_tx_status),
        .o_IRQ       (o_IRQ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bit period: the line must hold v for BD consecutive clocks
    task automatic check_bit(input logic v, input string tag);
        repeat (BD) begin
            chk(tag, {7'b0, o_UART_RX}, {7'b0, v});
            tick();
        end
    endtask

    task automatic check_data(input logic [7:0] b, input string tag);
        for (int i = 0; i < 8; i++) check_bit(b[i], tag);
        check_bit(1'b1, {tag, "_stop"});
    endtask

    task automatic check_frame(input logic [7:0] b, input string tag);
        check_bit(1'b0, {tag, "_start"});
        check_data(b, tag);
    endtask

    task automatic write(input logic [7:0] d);
        i_tx_wr   = 1'b1;
        i_tx_data = d;
        tick();
        i_tx_wr   = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        i_tx_wr     = 1'b0;
        i_tx_data   = 8'h00;
        i_control   = 8'h00;
        i_status_rd = 1'b0;
        tick();
        tick();
        chk("rst_line",   {7'b0, o_UART_RX}, 8'h01);
        chk("rst_status", o_tx_status,       8'h01);
        chk("rst_irq",    {7'b0, o_IRQ},     8'h01);
        reset = 1'b0;
        tick();

        // 1: single byte, latency and framing
        i_control = 8'h01;
        write(8'hA5);
        chk("t1_lat1", {7'b0, o_UART_RX}, 8'h01);
        tick();
        chk("t1_busy", o_tx_status, 8'h04);
        check_frame(8'hA5, "t1");
        chk("t1_status_end", o_tx_status, 8'h01);

        // 2: six writes in a row, five gap-free frames, sixth dropped
        write(8'h31);
        write(8'h32);
        write(8'h33);
        write(8'h34);
        write(8'h35);
        write(8'h36);
        chk("t2_full_ovr", o_tx_status, 8'h4E);
        check_data(8'h31, "t2_f1");
        check_frame(8'h32, "t2_f2");
        check_frame(8'h33, "t2_f3");
        check_frame(8'h34, "t2_f4");
        check_frame(8'h35, "t2_f5");
        chk("t2_ovr_sticky", o_tx_status, 8'h09);
        i_status_rd = 1'b1;
        tick();
        i_status_rd = 1'b0;
        chk("t2_ovr_clr", o_tx_status, 8'h01);

        // 3: disabled transmitter queues but does not send
        i_control = 8'h00;
        write(8'h11);
        write(8'h22);
        tick();
        tick();
        chk("t3_line_idle", {7'b0, o_UART_RX}, 8'h01);
        chk("t3_count2",    o_tx_status,       8'h20);
        i_control = 8'h01;
        tick();
        check_frame(8'h11, "t3_f1");
        check_frame(8'h22, "t3_f2");
        chk("t3_status_end", o_tx_status, 8'h01);

        // 4: IRQ follows tx_empty with one clock of latency
        i_control = 8'h03;
        tick();
        chk("t4_irq_idle", {7'b0, o_IRQ}, 8'h00);
        write(8'h55);
        chk("t4_irq_w0", {7'b0, o_IRQ}, 8'h00);
        tick();
        chk("t4_irq_busy", {7'b0, o_IRQ}, 8'h01);
        check_frame(8'h55, "t4");
        chk("t4_irq_lag", {7'b0, o_IRQ}, 8'h01);
        tick();
        chk("t4_irq_done", {7'b0, o_IRQ}, 8'h00);

        // 5: reset in the middle of data bit 3 aborts frame and queue
        i_control = 8'h01;
        write(8'hF0);
        write(8'h0F);
        write(8'h3C);
        repeat (16) tick();
        chk("t5_bit3", {7'b0, o_UART_RX}, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_line",   {7'b0, o_UART_RX}, 8'h01);
        chk("t5_status", o_tx_status,       8'h01);
        chk("t5_irq",    {7'b0, o_IRQ},     8'h01);
        repeat (10) tick();
        chk("t5_q_gone_line",   {7'b0, o_UART_RX}, 8'h01);
        chk("t5_q_gone_status", o_tx_status,       8'h01);

        // 6: flush with a coincident write while full and transmitting
        write(8'hC3);
        write(8'h01);
        write(8'h02);
        write(8'h03);
        write(8'h04);
        chk("t6_full", o_tx_status, 8'h46);
        i_control = 8'h05;
        write(8'h99);
        i_control = 8'h01;
        chk("t6_flushed", o_tx_status, 8'h04);
        check_data(8'hC3, "t6_f1");
        chk("t6_idle_status", o_tx_status, 8'h01);
        repeat (8) tick();
        chk("t6_idle_line",  {7'b0, o_UART_RX}, 8'h01);
        chk("t6_idle_final", o_tx_status,       8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
